// File: rtl/piso_pkg.sv
// Shared types for the piso_serial_tx transmitter.
// Optional PISO_PARITY_EN build adds the PAR state to the frame.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR,
        DONE
    } tx_state_t;

    localparam int DIV_W = 8;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: pulses tick once every CLKS_PER_BIT cycles while run is high.
// The counter is held at zero whenever run is low, so each frame starts on a clean period.
module bit_tick_gen
    import piso_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] TC = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] r_div;

    assign tick = run && (r_div == TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!run || tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and registered serial strobes.
// Define PISO_PARITY_EN to append an even-parity bit (PAR state) after the data bits.
//
// state | meaning
// IDLE  | in_ready high, waiting for a word
// SHIFT | data bits on sout, one per bit period
// PAR   | parity bit on sout (PISO_PARITY_EN builds only)
// DONE  | one-cycle done pulse, stream quiet
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MSB_FIRST    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             done
);

    localparam int             BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]  LAST_IDX = BW'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_nxt;
    logic [BW-1:0]    w_bit_inc;
    logic             r_sout;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic             r_ready;
    logic             w_sout_nxt;
    logic             w_valid_nxt;
    logic             w_last_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;
    logic             w_run;
    logic             w_tick;
    logic             w_hs;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif

    // The bit on the wire is always the head of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};
    assign w_bit_inc = r_bit_cnt + BW'(1);
    assign w_run     = (r_state == SHIFT) || (r_state == PAR);
    assign w_hs      = (r_state == IDLE) && in_valid && r_ready;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (w_run),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_sout_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_hs) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = in_data;
                    w_bit_nxt   = '0;
                    w_sout_nxt  = head_bit(in_data);
                    w_valid_nxt = 1'b1;
                    w_ready_nxt = 1'b0;
                end
            end
            SHIFT: begin
                w_valid_nxt = 1'b1;
                w_sout_nxt  = r_sout;
                w_last_nxt  = r_last;
                if (w_tick) begin
                    if (r_bit_cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                        w_state_nxt = PAR;
                        w_sout_nxt  = r_par;
                        w_last_nxt  = 1'b1;
`else
                        w_state_nxt = DONE;
                        w_sout_nxt  = 1'b0;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_bit_nxt   = w_bit_inc;
                        w_sout_nxt  = head_bit(w_shifted);
`ifdef PISO_PARITY_EN
                        w_last_nxt  = 1'b0;
`else
                        w_last_nxt  = (w_bit_inc == LAST_IDX);
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                w_valid_nxt = 1'b1;
                w_sout_nxt  = r_sout;
                w_last_nxt  = 1'b1;
                if (w_tick) begin
                    w_state_nxt = DONE;
                    w_sout_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            DONE: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sout    <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sout    <= w_sout_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity is taken from the word as loaded, since the shift register is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_hs) begin
            r_par <= ^in_data;
        end
    end
`endif

    assign in_ready   = r_ready;
    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign sout_last  = r_last;
    assign done       = r_done;

endmodule
